// File: rtl/bbox_frame_scheduler.sv
// Two-slot bounding-box scheduler: double-buffered box parameters
// committed at vertical blank, one shared outline sprite chosen per line.
module bbox_frame_scheduler #(
  parameter int unsigned STALE_FRAMES = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        new_frame_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        upd_valid_0_in,
  output logic        upd_ready_0_out,
  input  logic [11:0] upd_x_0_in,
  input  logic [10:0] upd_y_0_in,
  input  logic [11:0] upd_xmax_0_in,
  input  logic [10:0] upd_ymax_0_in,
  input  logic        upd_valid_1_in,
  output logic        upd_ready_1_out,
  input  logic [11:0] upd_x_1_in,
  input  logic [10:0] upd_y_1_in,
  input  logic [11:0] upd_xmax_1_in,
  input  logic [10:0] upd_ymax_1_in,
  output logic [11:0] x_out,
  output logic [10:0] y_out,
  output logic [11:0] xmax_out,
  output logic [10:0] ymax_out,
  output logic        box_en_out,
  output logic        slot_sel_out,
  output logic [1:0]  visible_out
);

  typedef enum logic {
    S_IDLE,
    S_COMMIT
  } state_t;

  localparam logic [3:0] STALE_MAX = 4'(STALE_FRAMES);

  state_t r_state;
  logic   r_ready;

  logic [1:0]       w_valid;
  logic [1:0]       w_acc;
  logic [1:0][11:0] w_ux;
  logic [1:0][10:0] w_uy;
  logic [1:0][11:0] w_uxm;
  logic [1:0][10:0] w_uym;

  logic [1:0][11:0] r_sh_x;
  logic [1:0][10:0] r_sh_y;
  logic [1:0][11:0] r_sh_xm;
  logic [1:0][10:0] r_sh_ym;
  logic [1:0][11:0] r_ac_x;
  logic [1:0][10:0] r_ac_y;
  logic [1:0][11:0] r_ac_xm;
  logic [1:0][10:0] r_ac_ym;
  logic [1:0]       r_pend;
  logic [1:0]       r_vis;
  logic [1:0][3:0]  r_stale;

  logic [1:0][11:0] w_sum;
  logic [1:0]       w_cover;
  logic             w_any;
  logic             w_sel;

  logic [11:0] r_x;
  logic [10:0] r_y;
  logic [11:0] r_xm;
  logic [10:0] r_ym;
  logic        r_en;
  logic        r_sel;

  assign w_valid = {upd_valid_1_in, upd_valid_0_in};
  assign w_ux    = {upd_x_1_in, upd_x_0_in};
  assign w_uy    = {upd_y_1_in, upd_y_0_in};
  assign w_uxm   = {upd_xmax_1_in, upd_xmax_0_in};
  assign w_uym   = {upd_ymax_1_in, upd_ymax_0_in};
  assign w_acc   = w_valid & {2{r_ready}};

  // Frame FSM; ready is registered so it tracks IDLE exactly
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (new_frame_in) begin
            r_state <= S_COMMIT;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Per-slot shadow capture, commit and staleness tracking
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sh_x  <= '0;
      r_sh_y  <= '0;
      r_sh_xm <= '0;
      r_sh_ym <= '0;
      r_ac_x  <= '0;
      r_ac_y  <= '0;
      r_ac_xm <= '0;
      r_ac_ym <= '0;
      r_pend  <= '0;
      r_vis   <= '0;
      r_stale <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_state == S_COMMIT) begin
          if (r_pend[k]) begin
            r_ac_x[k]  <= r_sh_x[k];
            r_ac_y[k]  <= r_sh_y[k];
            r_ac_xm[k] <= r_sh_xm[k];
            r_ac_ym[k] <= r_sh_ym[k];
            r_pend[k]  <= 1'b0;
            r_stale[k] <= 4'd0;
            r_vis[k]   <= 1'b1;
          end else if (r_stale[k] != STALE_MAX) begin
            r_stale[k] <= r_stale[k] + 4'd1;
            if (r_stale[k] + 4'd1 == STALE_MAX)
              r_vis[k] <= 1'b0;
          end else begin
            r_vis[k] <= 1'b0;
          end
        end else if (w_acc[k]) begin
          r_sh_x[k]  <= w_ux[k];
          r_sh_y[k]  <= w_uy[k];
          r_sh_xm[k] <= w_uxm[k];
          r_sh_ym[k] <= w_uym[k];
          r_pend[k]  <= 1'b1;
        end
      end
    end
  end

  // Line coverage test; 12-bit sums cannot wrap for these widths
  always_comb begin
    w_sum   = '0;
    w_cover = '0;
    for (int k = 0; k < 2; k++) begin
      w_sum[k]   = 12'(vcount_in) + 12'(r_ac_ym[k]);
      w_cover[k] = r_vis[k]
                 & (w_sum[k] >= {r_ac_y[k], 1'b0})
                 & ({1'b0, vcount_in} <= r_ac_ym[k]);
    end
  end

  assign w_any = |w_cover;
  assign w_sel = (&w_cover) ? vcount_in[0] : w_cover[1];

  // Latch the sprite for the whole line at hcount 0
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_x   <= '0;
      r_y   <= '0;
      r_xm  <= '0;
      r_ym  <= '0;
      r_en  <= 1'b0;
      r_sel <= 1'b0;
    end else if (hcount_in == 11'd0) begin
      r_en  <= w_any;
      r_sel <= w_any & w_sel;
      r_x   <= w_any ? r_ac_x[w_sel]  : 12'd0;
      r_y   <= w_any ? r_ac_y[w_sel]  : 11'd0;
      r_xm  <= w_any ? r_ac_xm[w_sel] : 12'd0;
      r_ym  <= w_any ? r_ac_ym[w_sel] : 11'd0;
    end
  end

  assign upd_ready_0_out = r_ready;
  assign upd_ready_1_out = r_ready;
  assign x_out           = r_x;
  assign y_out           = r_y;
  assign xmax_out        = r_xm;
  assign ymax_out        = r_ym;
  assign box_en_out      = r_en;
  assign slot_sel_out    = r_sel;
  assign visible_out     = r_vis;

endmodule

// File: doc/bbox_frame_scheduler.md
BBOX_FRAME_SCHEDULER -- requirements
Module: bbox_frame_scheduler

Interface
REQ-001 The block SHALL have parameter STALE_FRAMES, default 8, meaning the number of frames without an update after which a slot is hidden (range 1..15).
REQ-002 The block SHALL have port clk_in, input, 1 bit: pixel clock; the only clock.
REQ-003 The block SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port new_frame_in, input, 1 bit: one-cycle pulse at the start of vertical blank.
REQ-005 The block SHALL have port hcount_in, input, 11 bits, and port vcount_in, input, 10 bits: current pixel position.
REQ-006 The block SHALL have, for each requester k in {0,1}, port upd_valid_k_in, input, 1 bit: box update offered.
REQ-007 The block SHALL have, for each k, port upd_ready_k_out, output, 1 bit: update accepted when high together with valid.
REQ-008 The block SHALL have, for each k, ports upd_x_k_in (12 bits), upd_y_k_in (11 bits), upd_xmax_k_in (12 bits) and upd_ymax_k_in (11 bits), all inputs: box centre in half-pixel units and the right/bottom edge.
REQ-009 The block SHALL have outputs x_out (12), y_out (11), xmax_out (12), ymax_out (11): parameters for the single shared outline sprite.
REQ-010 The block SHALL have output box_en_out, 1 bit: sprite output is valid for the current line; the downstream blend gates on it.
REQ-011 The block SHALL have output slot_sel_out, 1 bit: which slot drives the current line.
REQ-012 The block SHALL have output visible_out, 2 bits: per-slot visible flag.

Function
REQ-013 Each slot k SHALL hold shadow registers, active registers, a pending flag, a 4-bit stale counter and a visible flag.
REQ-014 An update SHALL be accepted on a clock edge where upd_valid_k_in and upd_ready_k_out are both 1.
  - On acceptance, the shadow registers are written and the pending flag is set.
  - Later accepts before the commit overwrite the shadow (last write wins).
REQ-015 upd_ready_k_out SHALL be 1 in IDLE and 0 in COMMIT.
REQ-016 The frame FSM SHALL have two states, IDLE and COMMIT.
  - IDLE -> COMMIT when new_frame_in = 1.
  - COMMIT -> IDLE unconditionally after 1 cycle.
REQ-017 In COMMIT, for each slot:
  - pending = 1: copy shadow to active, clear pending, clear the stale counter, set visible = 1.
  - pending = 0: increment the stale counter, saturating at STALE_FRAMES; when it reaches STALE_FRAMES, set visible = 0.
REQ-018 An accept coinciding with new_frame_in SHALL be captured in the shadow, and the COMMIT that follows SHALL commit it.
REQ-019 Active registers SHALL change only in COMMIT, so parameters are never altered during active video.
REQ-020 Line scheduling SHALL occur when hcount_in == 0. A slot covers line v when it is visible, (v + ymax) >= (y << 1) and v <= ymax, with sums computed at 12 bits.
REQ-021 Slot selection at hcount_in == 0 SHALL be:
  - Neither slot covers: box_en_out = 0, and x/y/xmax/ymax_out = 0.
  - One slot covers: select that slot.
  - Both slots cover: select slot vcount_in[0] (slot 0 on even lines, slot 1 on odd lines).
REQ-022 The selection and sprite outputs SHALL be registered: they become valid 1 cycle after hcount_in == 0 and hold until the next hcount_in == 0.
REQ-023 Outputs SHALL never change mid-line, including during COMMIT; a commit takes effect on the next line scheduled.
REQ-024 No arithmetic SHALL wrap. A box whose (y << 1) exceeds ymax + 1023 never covers any line and is not an error.

Reset
REQ-025 While rst_n_in = 0, all registers SHALL clear immediately without waiting for a clock edge:
  - FSM = IDLE.
  - All shadow, active, pending, stale and visible registers = 0.
  - All outputs = 0, including both ready outputs.
REQ-026 On the first clock edge after reset release, upd_ready_k_out SHALL be 1.
REQ-027 A reset asserted mid-COMMIT or mid-line SHALL discard all pending and active state, with no partial commit retained.

Verification
REQ-028 Basic commit:
  - Stimulus: slot 0 update x=100, y=80, xmax=250, ymax=210, then new_frame_in.
  - Response: visible_out = 01; at v=150, box_en_out = 1, slot_sel_out = 0 and outputs are 100/80/250/210, 1 cycle after h=0; v=211 gives box_en_out = 0.
REQ-029 Overlap:
  - Stimulus: both slots cover v=150..151.
  - Response: slot_sel_out = 0 on line 150 and 1 on line 151.
REQ-030 Staleness:
  - Stimulus: STALE_FRAMES = 8, one update, then 8 further frames with no update.
  - Response: visible_out[0] drops to 0 on the 8th non-update COMMIT; box_en_out = 0 afterwards.
REQ-031 Handshake edge:
  - Stimulus: valid held through COMMIT.
  - Response: ready = 0 for exactly 1 cycle; an accept in the same cycle as new_frame_in is committed that frame.
REQ-032 Last write wins:
  - Stimulus: 3 updates on slot 1 within one frame.
  - Response: only the third update appears after the commit.
REQ-033 Reset mid-frame:
  - Stimulus: assert rst_n_in low between clock edges.
  - Response: all outputs are 0 at once; after release, no box is drawn until a new update and commit.
